// File: rtl/pmod_io_pkg.sv
// Shared definitions for the PMOD switch/LED controller: LED mode encoding
// and a ceiling-log2 helper used to size the debounce counters.
package pmod_io_pkg;

   typedef enum logic [1:0] {
      MODE_DIRECT = 2'd0,
      MODE_TOGGLE = 2'd1,
      MODE_LATCH  = 2'd2,
      MODE_COUNT  = 2'd3
   } mode_e;

   // Number of bits needed to hold the values 0 .. value-1 (at least 1).
   function automatic int clog2(input int value);
      int result;
      int remaining;
      result    = 0;
      remaining = value - 1;
      while (remaining > 0) begin
         result    = result + 1;
         remaining = remaining >> 1;
      end
      if (result == 0) begin
         result = 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/sw_debounce.sv
// Single switch channel: multi-flop synchroniser, debounce counter, stable
// pressed state and one-cycle press/release pulses.
module sw_debounce
   import pmod_io_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 120000,
   parameter int SYNC_STAGES     = 2,
   parameter int SW_ACTIVE_LOW   = 1
) (
   input  logic CLK,
   input  logic RST_N,
   input  logic sw_pin,
   output logic state,
   output logic rise,
   output logic fall
);

   localparam int               CNT_W          = clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST       = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic             RELEASED_LEVEL = (SW_ACTIVE_LOW != 0);

   logic [SYNC_STAGES-1:0] sync;
   logic [CNT_W-1:0]       cnt;
   logic                   pressed_raw;

   // Pin level as a "pressed" flag, taken from the last synchroniser flop.
   assign pressed_raw = sync[SYNC_STAGES-1] ^ RELEASED_LEVEL;

   // Synchroniser chain; reset fills it with the released pin level so no edge appears out of reset.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         sync <= {SYNC_STAGES{RELEASED_LEVEL}};
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], sw_pin};
      end
   end

   // Count consecutive mismatch cycles; any agreement restarts the count, a full count flips the state.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         cnt   <= '0;
         state <= 1'b0;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         rise <= 1'b0;
         fall <= 1'b0;
         if (pressed_raw != state) begin
            if (cnt == CNT_LAST) begin
               state <= pressed_raw;
               rise  <= pressed_raw;
               fall  <= ~pressed_raw;
               cnt   <= '0;
            end else begin
               cnt <= cnt + CNT_W'(1);
            end
         end else begin
            cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/pmod_switch_led_ctrl.sv
// PMOD switch-to-LED controller: debounces N_CH switches and drives N_CH LEDs
// in direct, toggle, sticky-latch or press-counter mode.
// Optional PWM brightness control is enabled by defining PMOD_LED_PWM_EN.
module pmod_switch_led_ctrl
   import pmod_io_pkg::*;
#(
   parameter int N_CH            = 8,
   parameter int DEBOUNCE_CYCLES = 120000,
   parameter int SYNC_STAGES     = 2,
   parameter int SW_ACTIVE_LOW   = 1,
   parameter int LED_ACTIVE_LOW  = 0,
   parameter int REVERSE         = 1
) (
   input  logic            CLK,
   input  logic            RST_N,
   input  logic [N_CH-1:0] sw_in,
   input  logic [1:0]      mode,
   input  logic            clr,
`ifdef PMOD_LED_PWM_EN
   input  logic [7:0]      brightness,
`endif
   output logic [N_CH-1:0] led_out,
   output logic [N_CH-1:0] sw_state,
   output logic [N_CH-1:0] sw_rise,
   output logic [N_CH-1:0] sw_fall
);

   localparam logic LED_POL = (LED_ACTIVE_LOW != 0);

   mode_e           mode_q;
   logic            clear;
   logic [N_CH-1:0] m;
   logic [N_CH-1:0] m_next;
   logic [N_CH-1:0] count;
   logic [N_CH-1:0] count_next;
   logic [N_CH-1:0] rise_pop;
   logic [N_CH-1:0] lit;
   logic [N_CH-1:0] lit_drive;
   logic [N_CH-1:0] led_next;

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      sw_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .SYNC_STAGES     (SYNC_STAGES),
         .SW_ACTIVE_LOW   (SW_ACTIVE_LOW)
      ) u_debounce (
         .CLK    (CLK),
         .RST_N  (RST_N),
         .sw_pin (sw_in[g]),
         .state  (sw_state[g]),
         .rise   (sw_rise[g]),
         .fall   (sw_fall[g])
      );
   end

   // A mode change behaves exactly like clr, and either one discards a same-cycle press.
   assign clear = clr | (mode != mode_q);

   // Registered mode plus per-channel mode state and the shared press counter.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         mode_q <= MODE_DIRECT;
         m      <= '0;
         count  <= '0;
      end else begin
         mode_q <= mode_e'(mode);
         m      <= m_next;
         count  <= count_next;
      end
   end

   // Number of channels that saw a debounced press this cycle.
   always_comb begin
      rise_pop = '0;
      for (int i = 0; i < N_CH; i++) begin
         rise_pop = rise_pop + N_CH'(sw_rise[i]);
      end
   end

   // Next mode state: clear has priority, otherwise the active mode consumes the press pulses.
   always_comb begin
      m_next     = m;
      count_next = count;
      if (clear) begin
         m_next     = '0;
         count_next = '0;
      end else begin
         case (mode_q)
            MODE_TOGGLE: m_next     = m ^ sw_rise;
            MODE_LATCH:  m_next     = m | sw_rise;
            MODE_COUNT:  count_next = count + rise_pop;
            default:     m_next     = m;
         endcase
      end
   end

   // Select which per-channel value lights the LEDs in the current mode.
   always_comb begin
      lit = sw_state;
      case (mode_q)
         MODE_DIRECT: lit = sw_state;
         MODE_TOGGLE: lit = m;
         MODE_LATCH:  lit = m;
         MODE_COUNT:  lit = count;
         default:     lit = sw_state;
      endcase
   end

`ifdef PMOD_LED_PWM_EN
   logic [7:0] pwm_cnt;

   // Free-running PWM phase counter shared by all channels.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         pwm_cnt <= 8'd0;
      end else begin
         pwm_cnt <= pwm_cnt + 8'd1;
      end
   end

   assign lit_drive = lit & {N_CH{pwm_cnt < brightness}};
`else
   assign lit_drive = lit;
`endif

   // Apply LED polarity and the optional bit reversal between channel and pin.
   always_comb begin
      led_next = '0;
      for (int i = 0; i < N_CH; i++) begin
         led_next[(REVERSE != 0) ? (N_CH - 1 - i) : i] = lit_drive[i] ^ LED_POL;
      end
   end

   // LED pins are registered; reset leaves every LED unlit.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         led_out <= {N_CH{LED_POL}};
      end else begin
         led_out <= led_next;
      end
   end

endmodule

// File: tb/tb_pmod_switch_led_ctrl.sv
// Directed self-checking bench for pmod_switch_led_ctrl with a short debounce
// (DEBOUNCE_CYCLES=4, SYNC_STAGES=2). The PWM section runs only when
// PMOD_LED_PWM_EN is defined.
module tb_pmod_switch_led_ctrl;

   logic       CLK;
   logic       RST_N;
   logic [7:0] sw_in;
   logic [1:0] mode;
   logic       clr;
`ifdef PMOD_LED_PWM_EN
   logic [7:0] brightness;
`endif
   logic [7:0] led_out;
   logic [7:0] sw_state;
   logic [7:0] sw_rise;
   logic [7:0] sw_fall;

   int checks   = 0;
   int failures = 0;

   pmod_switch_led_ctrl #(
      .N_CH            (8),
      .DEBOUNCE_CYCLES (4),
      .SYNC_STAGES     (2),
      .SW_ACTIVE_LOW   (1),
      .LED_ACTIVE_LOW  (0),
      .REVERSE         (1)
   ) dut (
      .CLK        (CLK),
      .RST_N      (RST_N),
      .sw_in      (sw_in),
      .mode       (mode),
      .clr        (clr),
`ifdef PMOD_LED_PWM_EN
      .brightness (brightness),
`endif
      .led_out    (led_out),
      .sw_state   (sw_state),
      .sw_rise    (sw_rise),
      .sw_fall    (sw_fall)
   );

   // 10 ns system clock.
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic waitCycles(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Switch pins are active low: pressed drives the pin to 0.
   task automatic applyStimulus(input int ch, input logic pressed);
      sw_in[ch] = ~pressed;
   endtask

   task automatic pressRelease(input int ch);
      applyStimulus(ch, 1'b1);
      waitCycles(8);
      applyStimulus(ch, 1'b0);
      waitCycles(8);
   endtask

   // Linear sequence of directed steps.
   initial begin
      int edge_pulses;
      int rises;
      RST_N = 1'b0;
      sw_in = 8'hFF;
      mode  = 2'd0;
      clr   = 1'b0;
`ifdef PMOD_LED_PWM_EN
      brightness = 8'd255;
`endif
      waitCycles(3);
      checkOutput("reset_led", led_out, 8'h00);
      checkOutput("reset_state", sw_state, 8'h00);
      checkOutput("reset_rise", sw_rise, 8'h00);
      checkOutput("reset_fall", sw_fall, 8'h00);
      RST_N = 1'b1;
      waitCycles(3);
      checkOutput("idle_led", led_out, 8'h00);

      // DIRECT: press ch0, flip 6 cycles later, LED one cycle after that.
      applyStimulus(0, 1'b1);
      waitCycles(5);
      checkOutput("direct_pre_state", sw_state, 8'h00);
      waitCycles(1);
      checkOutput("direct_state", sw_state, 8'h01);
      checkOutput("direct_rise", sw_rise, 8'h01);
      checkOutput("direct_led_lag", led_out, 8'h00);
      waitCycles(1);
      checkOutput("direct_rise_end", sw_rise, 8'h00);
      checkOutput("direct_led", led_out, 8'h80);
      applyStimulus(0, 1'b0);
      waitCycles(6);
      checkOutput("direct_fall", sw_fall, 8'h01);
      checkOutput("direct_release_state", sw_state, 8'h00);
      waitCycles(1);
      checkOutput("direct_release_led", led_out, 8'h00);
      waitCycles(2);

      // Bounce on ch3 every 2 cycles: no pulses, then one clean press.
      edge_pulses = 0;
      for (int i = 0; i < 10; i++) begin
         applyStimulus(3, (i % 2) == 0);
         repeat (2) begin
            waitCycles(1);
            if ((sw_rise != 8'h00) || (sw_fall != 8'h00)) edge_pulses++;
         end
      end
      checkOutput("bounce_quiet", 8'(edge_pulses), 8'd0);
      applyStimulus(3, 1'b1);
      waitCycles(5);
      checkOutput("bounce_hold_pre", sw_state, 8'h00);
      waitCycles(1);
      checkOutput("bounce_hold_rise", sw_rise, 8'h08);
      rises = 0;
      repeat (10) begin
         waitCycles(1);
         if (sw_rise[3]) rises++;
      end
      checkOutput("bounce_single", 8'(rises), 8'd0);
      applyStimulus(3, 1'b0);
      waitCycles(8);

      // TOGGLE on ch2 (LED bit 5).
      mode = 2'd1;
      waitCycles(2);
      pressRelease(2);
      checkOutput("toggle_1", led_out, 8'h20);
      pressRelease(2);
      checkOutput("toggle_2", led_out, 8'h00);
      pressRelease(2);
      checkOutput("toggle_3", led_out, 8'h20);

      // LATCH: mode change clears, ch1 (LED bit 6) sticks until clr.
      mode = 2'd2;
      waitCycles(2);
      checkOutput("mode_change_clear", led_out, 8'h00);
      pressRelease(1);
      checkOutput("latch_set", led_out, 8'h40);
      waitCycles(10);
      checkOutput("latch_hold", led_out, 8'h40);
      clr = 1'b1;
      waitCycles(1);
      clr = 1'b0;
      waitCycles(2);
      checkOutput("latch_clr", led_out, 8'h00);

      // COUNT: 255 presses on ch0, then ch0+ch1 together wraps FF -> 01.
      mode = 2'd3;
      waitCycles(2);
      pressRelease(0);
      checkOutput("count_1", led_out, 8'h80);
      for (int i = 0; i < 254; i++) begin
         pressRelease(0);
      end
      checkOutput("count_full", led_out, 8'hFF);
      applyStimulus(0, 1'b1);
      applyStimulus(1, 1'b1);
      waitCycles(6);
      checkOutput("count_dual_rise", sw_rise, 8'h03);
      waitCycles(2);
      checkOutput("count_wrap", led_out, 8'h80);
      applyStimulus(0, 1'b0);
      applyStimulus(1, 1'b0);
      waitCycles(8);

      // TOGGLE: clr in the same cycle as sw_rise[4] discards that press.
      mode = 2'd1;
      waitCycles(2);
      checkOutput("count_to_toggle_clear", led_out, 8'h00);
      applyStimulus(4, 1'b1);
      waitCycles(6);
      checkOutput("clr_rise_sync", sw_rise, 8'h10);
      clr = 1'b1;
      waitCycles(1);
      clr = 1'b0;
      waitCycles(3);
      checkOutput("clr_wins", led_out, 8'h00);
      applyStimulus(4, 1'b0);
      waitCycles(8);
      pressRelease(4);
      checkOutput("toggle_ch4", led_out, 8'h08);

      // Reset mid-debounce: outputs drop at once, debounce restarts from scratch.
      mode = 2'd0;
      waitCycles(2);
      applyStimulus(0, 1'b1);
      waitCycles(8);
      checkOutput("direct_held", led_out, 8'h80);
      applyStimulus(5, 1'b1);
      waitCycles(3);
      RST_N = 1'b0;
      #1;
      checkOutput("rst_state", sw_state, 8'h00);
      checkOutput("rst_led", led_out, 8'h00);
      waitCycles(2);
      RST_N = 1'b1;
      checkOutput("rst_no_rise", sw_rise, 8'h00);
      waitCycles(5);
      checkOutput("rst_discard", sw_state, 8'h00);
      waitCycles(1);
      checkOutput("rst_rearm", sw_state, 8'h21);
      waitCycles(2);

`ifdef PMOD_LED_PWM_EN
      // PWM: ch0 lit, brightness 64 lights the pin 64 of 256 cycles, 0 never.
      brightness = 8'd64;
      waitCycles(2);
      rises = 0;
      repeat (256) begin
         waitCycles(1);
         if (led_out[7]) rises++;
      end
      checkOutput("pwm_64", 8'(rises), 8'd64);
      brightness = 8'd0;
      waitCycles(2);
      rises = 0;
      repeat (256) begin
         waitCycles(1);
         if (led_out[7]) rises++;
      end
      checkOutput("pwm_0", 8'(rises), 8'd0);
`endif

      sw_in = 8'hFF;
      waitCycles(8);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pmod_switch_led_ctrl.md
Name: pmod_switch_led_ctrl

Overview:
- Parametrised successor to the plain switch-to-LED pass-through on the PMOD header.
- Synchronises and debounces N_CH switch inputs, then generates one-cycle press/release pulses.
- Drives N_CH LEDs in one of four runtime-selectable modes: direct, toggle, sticky latch, press counter.
- Sits between the PMOD switch pins and the PMOD LED pins in the top level. Debounced state and edge pulses are also exported for other logic.

Parameters:
- N_CH, 8, number of switch/LED channels (1..16).
- DEBOUNCE_CYCLES, 120000, cycles a synchronised input must hold a new level before it is accepted (10 ms at 12 MHz); minimum 2.
- SYNC_STAGES, 2, synchroniser flops per input (minimum 2).
- SW_ACTIVE_LOW, 1, 1 = switch pressed when pin reads 0.
- LED_ACTIVE_LOW, 0, 1 = LED lit when pin driven 0.
- REVERSE, 1, 1 = channel i drives led_out[N_CH-1-i]; 0 = led_out[i].

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  asynchronous active-low reset.
- sw_in  in  N_CH  raw switch pins, asynchronous.
- mode  in  2  0 DIRECT, 1 TOGGLE, 2 LATCH, 3 COUNT.
- clr  in  1  synchronous clear of mode state (toggle/latch/count registers).
- led_out  out  N_CH  LED pins, registered.
- sw_state  out  N_CH  debounced pressed state, 1 = pressed.
- sw_rise  out  N_CH  one-cycle pulse on debounced press.
- sw_fall  out  N_CH  one-cycle pulse on debounced release.

Behaviour:
- Reset, asynchronous on RST_N low:
  - Synchroniser flops and debounced state are loaded with "released".
  - Counters, toggle, latch and count registers = 0; sw_state = 0, sw_rise = 0, sw_fall = 0.
  - led_out = all LEDs unlit (all 1s if LED_ACTIVE_LOW, else 0).
  - Reset asserted mid-debounce discards the partial count. No edge pulse is generated out of reset.
- Input polarity: pressed_raw = sync_out XOR SW_ACTIVE_LOW.
- Debounce, per channel:
  - A counter runs while pressed_raw != sw_state.
  - The counter clears on any cycle where pressed_raw == sw_state, so glitches restart it.
  - When the counter reaches DEBOUNCE_CYCLES-1 and the mismatch persists, sw_state flips on the next edge. The counter clears on that same edge.
  - Counter width = clog2(DEBOUNCE_CYCLES); it must never wrap.
- Edges: sw_rise and sw_fall are registered and assert on the same edge that sw_state flips, for exactly one cycle.
- Latency: a pin change held stable reaches sw_state after SYNC_STAGES + DEBOUNCE_CYCLES cycles. led_out follows one cycle after sw_state or the mode-state update.
- Mode state machine (per-channel register m[i]):
  - DIRECT: lit[i] = sw_state[i].
  - TOGGLE: m[i] inverts on sw_rise[i]; lit = m.
  - LATCH: m[i] is set on sw_rise[i] and held until clr; lit = m.
  - COUNT: single N_CH-bit counter adds popcount(sw_rise) each cycle, wraps modulo 2^N_CH; lit = counter. At full count, adding k wraps to k-1.
- Mode change: mode is registered. Any cycle where mode differs from its registered value clears m and the counter, identical to clr.
- Simultaneous events: clr (or a mode change) and sw_rise in the same cycle → clear wins and that edge is discarded.
- Output mapping: led_out bit = lit[ch] XOR LED_ACTIVE_LOW, with REVERSE mapping applied.
- Defaults in DIRECT mode reproduce the legacy behaviour: LED pin = NOT switch pin, bit-reversed, but now debounced.

Optional Feature:
- Macro: PMOD_LED_PWM_EN.
- Defined:
  - Adds input brightness [7:0] and a free-running 8-bit PWM counter (reset 0).
  - A lit LED is driven lit only while pwm_cnt < brightness, so brightness 0 = always unlit and 255 = lit 255 of 256 cycles.
  - Unlit LEDs are unaffected.
- Undefined: no brightness port; lit LEDs are continuously lit.

Decomposition:
- Shared package pmod_io_pkg:
  - mode encoding constants MODE_DIRECT=0, MODE_TOGGLE=1, MODE_LATCH=2, MODE_COUNT=3.
  - clog2 helper function.
- Sub-module sw_debounce: single channel containing synchroniser, debounce counter, stable state and rise/fall pulses. Instantiated N_CH times in a generate loop.

Test Plan (bench uses DEBOUNCE_CYCLES=4, SYNC_STAGES=2):
- Reset with sw_in=8'hFF, mode=0 → led_out=8'h00, sw_state=0. Drive sw_in[0]=0 held → sw_state[0]=1 and sw_rise[0] one pulse 6 cycles later; led_out=8'h80 the next cycle.
- Bounce: toggle sw_in[3] every 2 cycles for 20 cycles, then hold 0 → no edge pulses during bounce; exactly one sw_rise[3] pulse 6 cycles after the hold.
- TOGGLE: three debounced presses on ch2 → led_out bit5 = 1, 0, 1. LATCH: press and release ch1 → bit6 stays 1 until clr, then 0.
- COUNT: 255 presses on ch0, then a simultaneous press on ch0 and ch1 → counter wraps 8'hFF → 8'h01; led_out shows the bit-reversed value.
- clr asserted in the same cycle as sw_rise[4] in TOGGLE → m[4] stays 0. Switching mode 1→2 clears all m. Asserting RST_N=0 mid-debounce → all outputs return to reset values immediately.
- With PMOD_LED_PWM_EN defined, brightness=64 and ch0 lit → led_out[7] high for 64 of every 256 cycles. brightness=0 → never high.
